rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_reader.sv | 164 ++++++++++++++++
 tb/tb_rom_stream_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Sweeps a wrap-around address range of a registered-output ROM and re-emits the words
// on a valid/ready stream, absorbing the one-cycle read latency with a credit-checked FIFO.
module rom_stream_reader #(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 64,
  localparam int unsigned AW = $clog2(MEM_DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 done,
  output logic                 rom_enable,
  output logic [AW-1:0]        rom_address,
  input  logic [MEM_WIDTH-1:0] rom_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MEM_WIDTH-1:0] m_data,
  output logic                 m_last
);

  localparam int unsigned FifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          done_q, done_d;

  // One read may be in flight: the ROM returns data the cycle after its enable.
  logic inflight_q;
  logic inflight_last_q;

  logic [MEM_WIDTH-1:0] fifo_data_q [FifoDepth];
  logic                 fifo_last_q [FifoDepth];
  logic [1:0]           wr_ptr_q, rd_ptr_q;
  logic [2:0]           occ_q, occ_d;

  logic [2:0] outstanding;
  logic       credit_ok;
  logic       issue;
  logic       push;
  logic       pop;
  logic       last_hs;

  assign outstanding = occ_q + {2'b00, inflight_q};
  assign credit_ok   = (outstanding < 3'd4);
  assign issue       = (state_q == StIssue) && credit_ok && (remaining_q != '0);

  assign push    = inflight_q;
  assign m_valid = (occ_q != 3'd0);
  assign pop     = m_valid && m_ready;
  // Head data is gated so the stream reads as zero whenever nothing is valid.
  assign m_data  = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last  = m_valid && fifo_last_q[rd_ptr_q];
  assign last_hs = pop && m_last;

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign rom_enable  = issue;
  assign rom_address = issue ? ptr_q : last_addr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            ptr_d       = start_addr;
            remaining_d = count;
            state_d     = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          ptr_d       = (ptr_q == AW'(MEM_DEPTH - 1)) ? '0 : ptr_q + AW'(1);
          remaining_d = remaining_q - CW'(1);
          last_addr_d = ptr_q;
          if (remaining_q == CW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (last_hs) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      last_addr_q     <= '0;
      remaining_q     <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      last_addr_q     <= last_addr_d;
      remaining_q     <= remaining_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == CW'(1));
      occ_q           <= occ_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rom_dout;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (occ_q == 3'(FifoDepth))));
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a behavioural registered-output 64x32 ROM.
module tb_rom_stream_reader;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = 7;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          rom_enable;
  logic [AW-1:0] rom_address;
  logic [W-1:0]  rom_dout = '0;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;

  int n_checks = 0;
  int n_errors = 0;

  rom_stream_reader #(
    .MEM_WIDTH(W),
    .MEM_DEPTH(D)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_enable (rom_enable),
    .rom_address(rom_address),
    .rom_dout   (rom_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clock = ~clock;

  // Known sine/exp table entries; the rest get a distinct filler pattern.
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'd0:    rom_word = 32'h3f68c7b7;
      6'd1:    rom_word = 32'h3f65567d;
      6'd2:    rom_word = 32'h3f61abef;
      6'd3:    rom_word = 32'h3f5dc8f7;
      6'd36:   rom_word = 32'h3c87ebb8;
      6'd37:   rom_word = 32'hbc70232a;
      6'd62:   rom_word = 32'hbf36e963;
      6'd63:   rom_word = 32'hbf3c6b25;
      default: rom_word = {16'h5a00, 2'b00, a, 2'b00, ~a};
    endcase
  endfunction

  always @(posedge clock) begin
    if (rom_enable) rom_dout <= rom_word(rom_address);
  end

  // Passive monitor, sampled on the falling edge.
  int          n_issue = 0;
  int          n_done = 0;
  int          n_busy_cyc = 0;
  int          outstanding = 0;
  int          max_out = 0;
  int          n_stall_err = 0;
  int          n_last_done_same = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [5:0]  addr_log [$];
  logic [31:0] beat_log [$];
  logic        last_log [$];

  always @(negedge clock) begin
    if (!reset_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (rom_enable) begin
        addr_log.push_back(rom_address);
        n_issue++;
        outstanding++;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (prev_stall && (!m_valid || m_data != prev_data)) n_stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        beat_log.push_back(m_data);
        last_log.push_back(m_last);
        outstanding--;
      end
      if (done) n_done++;
      if (busy) n_busy_cyc++;
      if (done && m_valid && m_last) n_last_done_same++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_rom_enable"}, 32'(rom_enable), 32'd0);
    check_eq({tag, "_rom_address"}, 32'(rom_address), 32'd0);
    check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_eq({tag, "_m_data"}, m_data, 32'd0);
    check_eq({tag, "_m_last"}, 32'(m_last), 32'd0);
  endtask

  // Start in cycle 0; returns the cycle in which done was seen, or -1 on timeout.
  task automatic run_sweep(input logic [5:0] addr, input logic [6:0] cnt, input int ready_pct,
                           input bit poke, output int done_cycle);
    start_addr = addr;
    count      = cnt;
    start      = 1'b1;
    m_ready    = 1'b1;
    step();
    done_cycle = -1;
    for (int k = 1; k < 3000; k++) begin
      if (poke && k == 2) begin
        start      = 1'b1;
        start_addr = addr + 6'd9;
        count      = 7'd3;
      end else begin
        start = 1'b0;
      end
      m_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
      if (done) begin
        done_cycle = k;
        break;
      end
      step();
    end
    start   = 1'b0;
    m_ready = 1'b1;
  endtask

  logic [31:0] exp4 [4];
  logic [31:0] expw [4];
  logic [5:0]  expa [4];

  initial begin
    int dc;
    int b0;
    int a0;
    int d0;
    int i0;
    int bz;
    int mism;
    int nlast;

    exp4[0] = 32'h3f68c7b7; exp4[1] = 32'h3f65567d;
    exp4[2] = 32'h3f61abef; exp4[3] = 32'h3f5dc8f7;
    expw[0] = 32'hbf36e963; expw[1] = 32'hbf3c6b25;
    expw[2] = 32'h3f68c7b7; expw[3] = 32'h3f65567d;
    expa[0] = 6'd62; expa[1] = 6'd63; expa[2] = 6'd0; expa[3] = 6'd1;

    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    m_ready    = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Basic sweep with exact cycle timing.
    start_addr = 6'd0;
    count      = 7'd4;
    m_ready    = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    check_eq("c1_rom_enable", 32'(rom_enable), 32'd1);
    check_eq("c1_rom_address", 32'(rom_address), 32'd0);
    check_eq("c1_busy", 32'(busy), 32'd1);
    check_eq("c1_m_valid", 32'(m_valid), 32'd0);
    step();
    check_eq("c2_rom_address", 32'(rom_address), 32'd1);
    check_eq("c2_m_valid", 32'(m_valid), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("beat%0d_valid", i), 32'(m_valid), 32'd1);
      check_eq($sformatf("beat%0d_data", i), m_data, exp4[i]);
      check_eq($sformatf("beat%0d_last", i), 32'(m_last), 32'(i == 3));
      check_eq($sformatf("beat%0d_done", i), 32'(done), 32'd0);
      step();
    end
    check_eq("c7_done", 32'(done), 32'd1);
    check_eq("c7_m_valid", 32'(m_valid), 32'd0);
    check_eq("c7_rom_enable", 32'(rom_enable), 32'd0);
    step();
    check_eq("c8_done", 32'(done), 32'd0);
    check_eq("c8_busy", 32'(busy), 32'd0);

    // Back-to-back start in the cycle after done, wrapping range, start poked while busy.
    b0 = beat_log.size();
    a0 = addr_log.size();
    d0 = n_done;
    run_sweep(6'd62, 7'd4, 100, 1'b1, dc);
    check_eq("wrap_done_cycle", 32'(dc), 32'd7);
    step();
    check_eq("wrap_done_count", 32'(n_done - d0), 32'd1);
    check_eq("wrap_beats", 32'(beat_log.size() - b0), 32'd4);
    check_eq("wrap_issues", 32'(addr_log.size() - a0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (b0 + i < beat_log.size()) begin
        check_eq($sformatf("wrap_data%0d", i), beat_log[b0 + i], expw[i]);
        check_eq($sformatf("wrap_last%0d", i), 32'(last_log[b0 + i]), 32'(i == 3));
      end
      if (a0 + i < addr_log.size()) begin
        check_eq($sformatf("wrap_addr%0d", i), 32'(addr_log[a0 + i]), 32'(expa[i]));
      end
    end
    repeat (2) step();

    // Full-depth sweep under random backpressure.
    b0 = beat_log.size();
    i0 = 0;
    run_sweep(6'd5, 7'd64, 30, 1'b0, dc);
    check_eq("bp_done_seen", 32'(dc > 0), 32'd1);
    step();
    check_eq("bp_beats", 32'(beat_log.size() - b0), 32'd64);
    mism  = 0;
    nlast = 0;
    for (int i = 0; i < 64; i++) begin
      if (b0 + i < beat_log.size()) begin
        if (beat_log[b0 + i] != rom_word(6'(5 + i))) mism++;
        if (last_log[b0 + i]) nlast++;
        if (i == 63) i0 = int'(last_log[b0 + i]);
      end
    end
    check_eq("bp_data_mismatches", 32'(mism), 32'd0);
    check_eq("bp_last_count", 32'(nlast), 32'd1);
    check_eq("bp_last_on_final", 32'(i0), 32'd1);
    check_eq("bp_max_outstanding", 32'(max_out), 32'd4);
    check_eq("bp_stall_unstable", 32'(n_stall_err), 32'd0);
    check_eq("last_and_done_overlap", 32'(n_last_done_same), 32'd0);
    repeat (2) step();

    // Zero-length command.
    a0 = n_issue;
    b0 = beat_log.size();
    bz = n_busy_cyc;
    start_addr = 6'd9;
    count      = 7'd0;
    start      = 1'b1;
    step();
    start = 1'b0;
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_busy", 32'(busy), 32'd0);
    step();
    check_eq("zero_done_pulse_end", 32'(done), 32'd0);
    repeat (3) step();
    check_eq("zero_no_issue", 32'(n_issue - a0), 32'd0);
    check_eq("zero_no_beats", 32'(beat_log.size() - b0), 32'd0);
    check_eq("zero_busy_cycles", 32'(n_busy_cyc - bz), 32'd0);

    // Reset in the middle of a sweep, then a fresh sweep must carry no stale data.
    start_addr = 6'h20;
    count      = 7'd10;
    m_ready    = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check_eq("mid_third_beat", m_data, rom_word(6'h22));
    reset_n = 1'b0;
    step();
    check_all_zero("mid_reset");
    reset_n = 1'b1;
    step();
    b0 = beat_log.size();
    run_sweep(6'h24, 7'd2, 100, 1'b0, dc);
    check_eq("post_reset_done_cycle", 32'(dc), 32'd5);
    step();
    check_eq("post_reset_beats", 32'(beat_log.size() - b0), 32'd2);
    if (beat_log.size() - b0 >= 2) begin
      check_eq("post_reset_data0", beat_log[b0], 32'h3c87ebb8);
      check_eq("post_reset_data1", beat_log[b0 + 1], 32'hbc70232a);
      check_eq("post_reset_last1", 32'(last_log[b0 + 1]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
